// File: rtl/pcx_pkg.sv
// pcx_pkg
// Shared definitions for the PC / exception sequencer and its neighbours.
//   - pcx_state_e : sequencer state encoding (IDLE/REQ/WAIT/LOAD, 2 bits)
//   - CAUSE_*     : exception cause codes, as seen on exc_cause
//   - VEC_*       : default handler-byte addresses, shared with the memory
//                   init image and the control unit
//   - pcx_vector  : maps a cause code onto its handler-byte address
package pcx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } pcx_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_DIV0     = 2'b11;

    localparam logic [31:0] DEF_EPC_OFFSET   = 32'd4;
    localparam logic [31:0] VEC_OPCODE_ADDR   = 32'd253;
    localparam logic [31:0] VEC_OVERFLOW_ADDR = 32'd254;
    localparam logic [31:0] VEC_DIV0_ADDR     = 32'd255;

    // CAUSE_NONE never reaches the vector fetch; it falls through to the
    // div0 slot only so the mux is fully specified.
    function automatic logic [31:0] pcx_vector(
        input logic [1:0]  cause,
        input logic [31:0] vec_opcode,
        input logic [31:0] vec_overflow,
        input logic [31:0] vec_div0
    );
        case (cause)
            CAUSE_OPCODE:   pcx_vector = vec_opcode;
            CAUSE_OVERFLOW: pcx_vector = vec_overflow;
            default:        pcx_vector = vec_div0;
        endcase
    endfunction

endpackage

// File: rtl/pcx_cause_enc.sv
// pcx_cause_enc
// Combinational priority encoder from the three exception lines to a 2-bit
// cause code. Priority: opcode > overflow > div0.
// Ports:
//   exc_opcode   in   1  invalid-opcode exception
//   exc_overflow in   1  ALU overflow exception
//   exc_div0     in   1  divide-by-zero exception
//   cause        out  2  00 none, 01 opcode, 10 overflow, 11 div0
import pcx_pkg::*;

module pcx_cause_enc (
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic [1:0] cause
);

    always_comb begin
        cause = CAUSE_NONE;
        if (exc_opcode) begin
            cause = CAUSE_OPCODE;
        end else if (exc_overflow) begin
            cause = CAUSE_OVERFLOW;
        end else if (exc_div0) begin
            cause = CAUSE_DIV0;
        end
    end

endmodule

// File: rtl/pc_exception_unit.sv
// pc_exception_unit
// Program-counter register plus exception sequencer. In IDLE the PC follows
// the PC source mux under pc_write / (pc_write_cond & branch_ok). An
// exception saves EPC = pc_out - EPC_OFFSET, then the unit reads the handler
// byte for that cause from memory and loads it (zero-extended) into the PC.
// Optional feature macro PCX_TIMEOUT_EN: bounds the wait for vec_ack to
// ACK_TIMEOUT cycles, after which PC takes DEFAULT_VECTOR and exc_timeout
// pulses. Without it the unit waits for the ack indefinitely.
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   pc_in          in  32   PC source mux output
//   pc_write       in  1    unconditional PC load
//   pc_write_cond  in  1    branch PC load, gated by branch_ok
//   branch_ok      in  1    resolved branch condition
//   exc_opcode/overflow/div0 in 1 exception lines, sampled in IDLE only
//   vec_ack        in  1    memory returned vec_data
//   vec_data       in  8    handler byte
//   vec_req        out 1    vector read request, held until ack
//   vec_addr       out 32   vector byte address, stable while vec_req
//   pc_out         out 32   current PC
//   epc_out        out 32   saved exception PC
//   exc_cause      out 2    cause of the exception being serviced
//   exc_busy       out 1    sequencer not in IDLE; control unit stalls
//   exc_timeout    out 1    one-cycle timeout pulse (0 without the macro)
import pcx_pkg::*;

module pc_exception_unit #(
    parameter logic [31:0] EPC_OFFSET     = DEF_EPC_OFFSET,
    parameter logic [31:0] VEC_OPCODE     = VEC_OPCODE_ADDR,
    parameter logic [31:0] VEC_OVERFLOW   = VEC_OVERFLOW_ADDR,
    parameter logic [31:0] VEC_DIV0       = VEC_DIV0_ADDR,
    parameter int          ACK_TIMEOUT    = 8,
    parameter logic [31:0] DEFAULT_VECTOR = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_ok,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        vec_ack,
    input  logic [7:0]  vec_data,
    output logic        vec_req,
    output logic [31:0] vec_addr,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [1:0]  exc_cause,
    output logic        exc_busy,
    output logic        exc_timeout
);

    pcx_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] vec_addr_q, vec_addr_d;
    logic [1:0]  cause_q, cause_d;
    logic        vec_req_q, vec_req_d;
    logic [7:0]  vec_data_q, vec_data_d;
    logic [1:0]  enc_cause;

`ifdef PCX_TIMEOUT_EN
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{DEFAULT_VECTOR, 32'(ACK_TIMEOUT)};
`endif

    pcx_cause_enc u_cause_enc (
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .cause        (enc_cause)
    );

    // Next-state logic. Exceptions are only looked at in IDLE, which is
    // what masks exc_* and pc_write* while the sequencer is busy.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        vec_addr_d = vec_addr_q;
        cause_d    = cause_q;
        vec_req_d  = vec_req_q;
        vec_data_d = vec_data_q;
`ifdef PCX_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // An exception takes precedence over a same-cycle PC load.
                if (enc_cause != CAUSE_NONE) begin
                    epc_d   = pc_q - EPC_OFFSET;
                    cause_d = enc_cause;
                    state_d = ST_REQ;
                end else if (pc_write | (pc_write_cond & branch_ok)) begin
                    pc_d = pc_in;
                end
            end
            ST_REQ: begin
                vec_addr_d = pcx_vector(cause_q, VEC_OPCODE, VEC_OVERFLOW, VEC_DIV0);
                vec_req_d  = 1'b1;
                state_d    = ST_WAIT;
`ifdef PCX_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            ST_WAIT: begin
                if (vec_ack) begin
                    vec_data_d = vec_data;
                    vec_req_d  = 1'b0;
                    state_d    = ST_LOAD;
`ifdef PCX_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    vec_req_d = 1'b0;
                    pc_d      = DEFAULT_VECTOR;
                    cause_d   = CAUSE_NONE;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                pc_d    = {24'b0, vec_data_q};
                cause_d = CAUSE_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request,
    // so a late vec_ack lands in IDLE and is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            epc_q      <= '0;
            vec_addr_q <= '0;
            cause_q    <= CAUSE_NONE;
            vec_req_q  <= 1'b0;
            vec_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            vec_addr_q <= vec_addr_d;
            cause_q    <= cause_d;
            vec_req_q  <= vec_req_d;
            vec_data_q <= vec_data_d;
        end
    end

`ifdef PCX_TIMEOUT_EN
    // Ack-wait counter and the registered timeout pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign exc_timeout = timeout_q;
`else
    assign exc_timeout = 1'b0;
`endif

    assign vec_req   = vec_req_q;
    assign vec_addr  = vec_addr_q;
    assign pc_out    = pc_q;
    assign epc_out   = epc_q;
    assign exc_cause = cause_q;
    assign exc_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pc_exception_unit.sv
// tb_pc_exception_unit
// Directed bench for pc_exception_unit. Inputs change and outputs are
// sampled 1 ns after each rising edge. The timeout scenario is built only
// with PCX_TIMEOUT_EN; otherwise the indefinite ack wait is exercised.
module tb_pc_exception_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ok;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic        vec_ack;
    logic [7:0]  vec_data;
    logic        vec_req;
    logic [31:0] vec_addr;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic [1:0]  exc_cause;
    logic        exc_busy;
    logic        exc_timeout;

    int checks = 0;
    int errors = 0;

    pc_exception_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_in         (pc_in),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ok     (branch_ok),
        .exc_opcode    (exc_opcode),
        .exc_overflow  (exc_overflow),
        .exc_div0      (exc_div0),
        .vec_ack       (vec_ack),
        .vec_data      (vec_data),
        .vec_req       (vec_req),
        .vec_addr      (vec_addr),
        .pc_out        (pc_out),
        .epc_out       (epc_out),
        .exc_cause     (exc_cause),
        .exc_busy      (exc_busy),
        .exc_timeout   (exc_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_in         = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ok     = 1'b0;
        exc_opcode    = 1'b0;
        exc_overflow  = 1'b0;
        exc_div0      = 1'b0;
        vec_ack       = 1'b0;
        vec_data      = '0;
    endtask

    task automatic load_pc(input logic [31:0] value);
        pc_in    = value;
        pc_write = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        pc_in         = $urandom;
        pc_write      = 1'($urandom);
        pc_write_cond = 1'($urandom);
        branch_ok     = 1'($urandom);
        exc_opcode    = 1'($urandom);
        exc_overflow  = 1'($urandom);
        exc_div0      = 1'($urandom);
        vec_ack       = 1'($urandom);
        vec_data      = 8'($urandom);
        repeat (3) tick();
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
        end
        checks++;
        if (epc_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_epc: got %h expected %h", epc_out, 32'h0);
        end
        checks++;
        if ({vec_req, exc_busy, exc_cause, exc_timeout} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got req=%b busy=%b cause=%b to=%b expected all 0",
                     vec_req, exc_busy, exc_cause, exc_timeout);
        end
        checks++;
        if (vec_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_vec_addr: got %h expected %h", vec_addr, 32'h0);
        end
        clear_inputs();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_pc_load();
        load_pc(32'h40);
        checks++;
        if (pc_out !== 32'h40) begin
            errors++;
            $display("[TB] FAIL pc_write: got %h expected %h", pc_out, 32'h40);
        end
        pc_in         = 32'h80;
        pc_write_cond = 1'b1;
        branch_ok     = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'h40) begin
            errors++;
            $display("[TB] FAIL branch_not_taken: got %h expected %h", pc_out, 32'h40);
        end
        branch_ok = 1'b1;
        tick();
        checks++;
        if (pc_out !== 32'h80) begin
            errors++;
            $display("[TB] FAIL branch_taken: got %h expected %h", pc_out, 32'h80);
        end
        clear_inputs();
        pc_in = 32'hDEAD;
        tick();
        checks++;
        if (pc_out !== 32'h80) begin
            errors++;
            $display("[TB] FAIL pc_hold: got %h expected %h", pc_out, 32'h80);
        end
        pc_in = '0;
    endtask

    task automatic test_overflow();
        load_pc(32'h104);
        exc_overflow = 1'b1;
        tick();
        exc_overflow = 1'b0;
        checks++;
        if (epc_out !== 32'h100 || exc_cause !== 2'b10 || exc_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_save: got epc=%h cause=%b busy=%b expected epc=00000100 cause=10 busy=1",
                     epc_out, exc_cause, exc_busy);
        end
        tick();
        checks++;
        if (vec_req !== 1'b1 || vec_addr !== 32'd254) begin
            errors++;
            $display("[TB] FAIL ovf_req: got req=%b addr=%0d expected req=1 addr=254", vec_req, vec_addr);
        end
        vec_ack  = 1'b1;
        vec_data = 8'h3C;
        tick();
        vec_ack  = 1'b0;
        vec_data = 8'h00;
        checks++;
        if (vec_req !== 1'b0 || pc_out !== 32'h104) begin
            errors++;
            $display("[TB] FAIL ovf_ack: got req=%b pc=%h expected req=0 pc=00000104", vec_req, pc_out);
        end
        tick();
        checks++;
        if (pc_out !== 32'h3C || exc_cause !== 2'b00 || exc_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_load: got pc=%h cause=%b busy=%b expected pc=0000003c cause=00 busy=0",
                     pc_out, exc_cause, exc_busy);
        end
    endtask

    task automatic test_simultaneous();
        exc_opcode = 1'b1;
        exc_div0   = 1'b1;
        pc_write   = 1'b1;
        pc_in      = 32'h999;
        tick();
        clear_inputs();
        checks++;
        if (exc_cause !== 2'b01 || pc_out !== 32'h3C || epc_out !== 32'h38) begin
            errors++;
            $display("[TB] FAIL simul_save: got cause=%b pc=%h epc=%h expected cause=01 pc=0000003c epc=00000038",
                     exc_cause, pc_out, epc_out);
        end
        tick();
        checks++;
        if (vec_req !== 1'b1 || vec_addr !== 32'd253) begin
            errors++;
            $display("[TB] FAIL simul_req: got req=%b addr=%0d expected req=1 addr=253", vec_req, vec_addr);
        end
        vec_ack  = 1'b1;
        vec_data = 8'h10;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (pc_out !== 32'h10 || exc_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_load: got pc=%h busy=%b expected pc=00000010 busy=0", pc_out, exc_busy);
        end
    endtask

    task automatic test_masking();
        exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        checks++;
        if (exc_cause !== 2'b11 || epc_out !== 32'h0C) begin
            errors++;
            $display("[TB] FAIL div0_save: got cause=%b epc=%h expected cause=11 epc=0000000c", exc_cause, epc_out);
        end
        tick();
        exc_div0   = 1'b1;
        exc_opcode = 1'b1;
        pc_write   = 1'b1;
        pc_in      = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vec_req !== 1'b1 || vec_addr !== 32'd255 || exc_cause !== 2'b11 || pc_out !== 32'h10) begin
                errors++;
                $display("[TB] FAIL mask_wait%0d: got req=%b addr=%0d cause=%b pc=%h expected req=1 addr=255 cause=11 pc=00000010",
                         i, vec_req, vec_addr, exc_cause, pc_out);
            end
        end
        clear_inputs();
        vec_ack  = 1'b1;
        vec_data = 8'h22;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (pc_out !== 32'h22 || exc_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_load: got pc=%h busy=%b expected pc=00000022 busy=0", pc_out, exc_busy);
        end
        tick();
        checks++;
        if (exc_busy !== 1'b0 || exc_cause !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mask_idle: got busy=%b cause=%b expected busy=0 cause=00", exc_busy, exc_cause);
        end
    endtask

    task automatic test_reset_in_wait();
        exc_overflow = 1'b1;
        tick();
        exc_overflow = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (vec_req !== 1'b0 || exc_busy !== 1'b0 || pc_out !== 32'h0 || epc_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_wait: got req=%b busy=%b pc=%h epc=%h expected all 0",
                     vec_req, exc_busy, pc_out, epc_out);
        end
        #1;
        reset_n  = 1'b1;
        vec_ack  = 1'b1;
        vec_data = 8'h77;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (pc_out !== 32'h0 || exc_busy !== 1'b0 || vec_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_ack: got pc=%h busy=%b req=%b expected pc=00000000 busy=0 req=0",
                     pc_out, exc_busy, vec_req);
        end
    endtask

`ifdef PCX_TIMEOUT_EN
    task automatic test_timeout();
        load_pc(32'h208);
        exc_opcode = 1'b1;
        tick();
        exc_opcode = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++;
            if (vec_req !== 1'b1 || exc_timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL to_wait%0d: got req=%b to=%b expected req=1 to=0", i, vec_req, exc_timeout);
            end
        end
        tick();
        checks++;
        if (vec_req !== 1'b0 || exc_timeout !== 1'b1 || pc_out !== 32'h0 || exc_busy !== 1'b0 || exc_cause !== 2'b00) begin
            errors++;
            $display("[TB] FAIL to_fire: got req=%b to=%b pc=%h busy=%b cause=%b expected req=0 to=1 pc=00000000 busy=0 cause=00",
                     vec_req, exc_timeout, pc_out, exc_busy, exc_cause);
        end
        tick();
        checks++;
        if (exc_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_pulse: got %b expected 0", exc_timeout);
        end
    endtask
`else
    task automatic test_wait_hold();
        load_pc(32'h208);
        exc_opcode = 1'b1;
        tick();
        exc_opcode = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (vec_req !== 1'b1 || exc_timeout !== 1'b0 || exc_busy !== 1'b1 || vec_addr !== 32'd253) begin
                errors++;
                $display("[TB] FAIL hold_wait%0d: got req=%b to=%b busy=%b addr=%0d expected req=1 to=0 busy=1 addr=253",
                         i, vec_req, exc_timeout, exc_busy, vec_addr);
            end
        end
        vec_ack  = 1'b1;
        vec_data = 8'hA5;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (pc_out !== 32'hA5 || exc_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_load: got pc=%h busy=%b expected pc=000000a5 busy=0", pc_out, exc_busy);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_pc_load();
        test_overflow();
        test_simultaneous();
        test_masking();
        test_reset_in_wait();
`ifdef PCX_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
